// File: rtl/lcd_fmt_pkg.sv
// Shared types, command codes and DDRAM row addressing for the FIFO-to-LCD stream formatter.
package lcd_fmt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_ADDR,
        S_ITEM
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_NEXT_ROW,
        OP_CHAR,
        OP_CMD
    } cur_op_t;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    // Return-home ignores bit 0, so 8'h03 also homes the cursor.
    localparam logic [7:0] CMD_HOME_ALT  = 8'h03;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    function automatic logic [7:0] row_base(input logic [1:0] row);
        case (row)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h14;
            default: return 8'h54;
        endcase
    endfunction

endpackage

// File: rtl/lcd_cursor_tracker.sv
// Display cursor bookkeeping: row/column registers, next-row and wrap logic,
// inserted address/clear command and decode of host commands on accept.
module lcd_cursor_tracker
    import lcd_fmt_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter bit WRAP_CLEAR = 1'b1,
    parameter int ROW_W      = 1,
    parameter int COL_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  cur_op_t          op,
    input  logic [7:0]       cmd_data,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic             wrap_pending,
    output logic [7:0]       ins_cmd
);

    logic [ROW_W-1:0] next_row;
    logic             next_wraps;
    logic [7:0]       cmd_addr;
    logic             cmd_hit;
    logic [ROW_W-1:0] cmd_row;
    logic [COL_W-1:0] cmd_col;

    assign next_wraps   = (cur_row == ROW_W'(ROWS - 1));
    assign next_row     = next_wraps ? '0 : cur_row + ROW_W'(1);
    assign wrap_pending = (cur_col == COL_W'(COLS));
    assign ins_cmd      = (next_wraps && WRAP_CLEAR) ? CMD_CLEAR
                                                     : (CMD_SET_DDRAM | row_base(2'(next_row)));

    assign cmd_addr = {1'b0, cmd_data[6:0]};

    // Lowest row wins when windows overlap (wide panels with 4 rows).
    always_comb begin
        cmd_hit = 1'b0;
        cmd_row = '0;
        cmd_col = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (cmd_addr >= row_base(2'(r)) && cmd_addr < row_base(2'(r)) + 8'(COLS)) begin
                cmd_hit = 1'b1;
                cmd_row = ROW_W'(r);
                cmd_col = COL_W'(cmd_addr - row_base(2'(r)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_row <= '0;
            cur_col <= '0;
        end else begin
            case (op)
                OP_NEXT_ROW: begin
                    cur_row <= next_row;
                    cur_col <= '0;
                end
                OP_CHAR: cur_col <= cur_col + COL_W'(1);
                OP_CMD: begin
                    if (cmd_data inside {CMD_CLEAR, CMD_HOME, CMD_HOME_ALT}) begin
                        cur_row <= '0;
                        cur_col <= '0;
                    end else if (cmd_data[7]) begin
                        if (cmd_hit) begin
                            cur_row <= cmd_row;
                            cur_col <= cmd_col;
                        end else begin
                            // Off-screen address: force a re-address before the next char.
                            cur_col <= COL_W'(COLS);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lcd_stream_formatter.sv
// Pops {rs, data} entries from the sync FIFO and offers them to the HD44780 host port,
// inserting set-address/clear commands at line wrap and on newline.
module lcd_stream_formatter
    import lcd_fmt_pkg::*;
#(
    parameter int         COLS       = 16,
    parameter int         ROWS       = 2,
    parameter bit         NL_EN      = 1'b1,
    parameter logic [7:0] NL_CHAR    = 8'h0A,
    parameter bit         WRAP_CLEAR = 1'b1,
    localparam int        ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int        COL_W      = $clog2(COLS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [8:0]       fifo_dout,
    output logic             fifo_rd_en,
    input  logic             init_done,
    input  logic             host_ready,
    output logic             host_valid,
    output logic             host_rs,
    output logic [7:0]       host_data,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic             busy,
    output state_t           fsm_state
);

    // Host handshake: a transaction is accepted in any cycle where host_valid and
    // host_ready are both high; until then host_valid/host_rs/host_data hold steady.

    state_t     state;
    logic [8:0] item;
    logic       nl_pending;
    logic       accept;
    logic       cap_nl;
    logic       wrap_pending;
    logic [7:0] ins_cmd;
    cur_op_t    op;

    assign accept    = host_valid && host_ready;
    assign cap_nl    = NL_EN && fifo_dout[8] && (fifo_dout[7:0] == NL_CHAR);
    assign fsm_state = state;

    always_comb begin
        op = OP_NONE;
        if (accept) begin
            if (state == S_ADDR) begin
                op = OP_NEXT_ROW;
            end else if (state == S_ITEM) begin
                op = host_rs ? OP_CHAR : OP_CMD;
            end
        end
    end

    lcd_cursor_tracker #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .WRAP_CLEAR (WRAP_CLEAR),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W)
    ) u_cursor (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .cmd_data     (host_data),
        .cur_row      (cur_row),
        .cur_col      (cur_col),
        .wrap_pending (wrap_pending),
        .ins_cmd      (ins_cmd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            fifo_rd_en <= 1'b0;
            host_valid <= 1'b0;
            host_rs    <= 1'b0;
            host_data  <= 8'h00;
            busy       <= 1'b0;
            item       <= '0;
            nl_pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (init_done && !fifo_empty) begin
                        state      <= S_RD;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_RD: begin
                    fifo_rd_en <= 1'b0;
                    state      <= S_CAP;
                end
                S_CAP: begin
                    item       <= fifo_dout;
                    host_valid <= 1'b1;
                    nl_pending <= cap_nl;
                    if (cap_nl || (fifo_dout[8] && wrap_pending)) begin
                        host_rs   <= 1'b0;
                        host_data <= ins_cmd;
                        state     <= S_ADDR;
                    end else begin
                        host_rs   <= fifo_dout[8];
                        host_data <= fifo_dout[7:0];
                        state     <= S_ITEM;
                    end
                end
                S_ADDR: begin
                    if (accept) begin
                        if (nl_pending) begin
                            host_valid <= 1'b0;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            host_rs   <= item[8];
                            host_data <= item[7:0];
                            state     <= S_ITEM;
                        end
                    end
                end
                S_ITEM: begin
                    if (accept) begin
                        host_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    fifo_rd_en <= 1'b0;
                    host_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_stream_formatter.sv
// Directed bench for lcd_stream_formatter: a WRAP_CLEAR=1 and a WRAP_CLEAR=0 instance share stimulus.
module tb_lcd_stream_formatter;
    import lcd_fmt_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_done;
    logic       host_ready;
    logic       fifo_empty;
    logic [8:0] fifo_dout = '0;

    logic       fifo_rd_en, host_valid, host_rs, busy;
    logic [7:0] host_data;
    logic [0:0] cur_row;
    logic [4:0] cur_col;
    state_t     fsm_state;

    logic       fifo_rd_en_nc, host_valid_nc, host_rs_nc, busy_nc;
    logic [7:0] host_data_nc;
    logic [0:0] cur_row_nc;
    logic [4:0] cur_col_nc;
    state_t     fsm_state_nc;

    int         total = 0;
    int         bad = 0;
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         cyc = 0;
    logic [8:0] fifo_mem [0:127];
    logic [8:0] obs_q[$];
    logic [8:0] obs_nc_q[$];
    int         acc_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] exp_nc_q[$];

    lcd_stream_formatter #(
        .COLS(16), .ROWS(2), .NL_EN(1'b1), .NL_CHAR(8'h0A), .WRAP_CLEAR(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .init_done(init_done), .host_ready(host_ready),
        .host_valid(host_valid), .host_rs(host_rs), .host_data(host_data),
        .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .fsm_state(fsm_state)
    );

    lcd_stream_formatter #(
        .COLS(16), .ROWS(2), .NL_EN(1'b1), .NL_CHAR(8'h0A), .WRAP_CLEAR(1'b0)
    ) dut_nc (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en_nc), .init_done(init_done), .host_ready(host_ready),
        .host_valid(host_valid_nc), .host_rs(host_rs_nc), .host_data(host_data_nc),
        .cur_row(cur_row_nc), .cur_col(cur_col_nc), .busy(busy_nc), .fsm_state(fsm_state_nc)
    );

    // Clock / FIFO model / transaction monitor
    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_dout <= fifo_mem[rd_ptr % 128];
            rd_ptr    <= rd_ptr + 1;
        end
        if (host_valid && host_ready) begin
            obs_q.push_back({host_rs, host_data});
            acc_q.push_back(cyc);
        end
        if (host_valid_nc && host_ready) obs_nc_q.push_back({host_rs_nc, host_data_nc});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic push(input logic [8:0] v);
        fifo_mem[wr_ptr % 128] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wr_ptr == rd_ptr && !busy && !busy_nc) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Tests
    task automatic test_reset;
        rst_n = 1'b0;
        init_done = 1'b1;
        host_ready = 1'b1;
        #1;
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
        total++; if (host_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", host_valid); end
        total++; if (host_rs !== 1'b0) begin bad++; $display("FAIL rst_rs: got %b want 0", host_rs); end
        total++; if (host_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", host_data); end
        total++; if (cur_row !== 1'b0 || cur_col !== 5'd0) begin bad++; $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (fsm_state !== S_IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", fsm_state, S_IDLE); end
        total++; if (host_valid_nc !== 1'b0 || busy_nc !== 1'b0) begin bad++; $display("FAIL rst_nc: got valid=%b busy=%b want 0 0", host_valid_nc, busy_nc); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rst_idle_empty: got busy=%b rd_en=%b want 0 0", busy, fifo_rd_en); end
    endtask

    task automatic test_wrap_chars;
        int base, base_nc;
        bit ok;
        logic [8:0] got;
        base = obs_q.size();
        base_nc = obs_nc_q.size();
        exp_q.delete();
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            push({1'b1, 8'(8'h41 + i)});
            exp_q.push_back({1'b1, 8'(8'h41 + i)});
        end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_idle1: got timeout want idle"); end
        total++; if (cur_row !== 1'b0 || cur_col !== 5'd16) begin bad++; $display("FAIL wrap_col16: got (%0d,%0d) want (0,16)", cur_row, cur_col); end
        push({1'b1, 8'h51});
        exp_q.push_back({1'b0, 8'hC0});
        exp_q.push_back({1'b1, 8'h51});
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_idle2: got timeout want idle"); end
        total++;
        if (obs_q.size() - base != exp_q.size()) begin bad++; $display("FAIL wrap_count: got %0d want %0d", obs_q.size() - base, exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (base + i < obs_q.size()) ? obs_q[base + i] : 9'h1FF;
            total++;
            if (got !== exp_q[i]) begin bad++; $display("FAIL wrap_txn%0d: got %h want %h", i, got, exp_q[i]); end
            got = (base_nc + i < obs_nc_q.size()) ? obs_nc_q[base_nc + i] : 9'h1FF;
            total++;
            if (got !== exp_q[i]) begin bad++; $display("FAIL wrap_nc_txn%0d: got %h want %h", i, got, exp_q[i]); end
        end
        total++; if (cur_row !== 1'b1 || cur_col !== 5'd1) begin bad++; $display("FAIL wrap_final: got (%0d,%0d) want (1,1)", cur_row, cur_col); end
    endtask

    task automatic test_newline;
        int base, base_nc;
        bit ok;
        logic [8:0] got;
        base = obs_q.size();
        base_nc = obs_nc_q.size();
        push({1'b1, 8'h0A});
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL nl_idle: got timeout want idle"); end
        got = (obs_q.size() == base + 1) ? obs_q[base] : 9'h1FF;
        total++; if (got !== {1'b0, 8'h01}) begin bad++; $display("FAIL nl_clear_txn: got %h want 001 (single txn)", got); end
        got = (obs_nc_q.size() == base_nc + 1) ? obs_nc_q[base_nc] : 9'h1FF;
        total++; if (got !== {1'b0, 8'h80}) begin bad++; $display("FAIL nl_home_txn: got %h want 080 (single txn)", got); end
        total++; if (cur_row !== 1'b0 || cur_col !== 5'd0) begin bad++; $display("FAIL nl_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col); end
        total++; if (cur_row_nc !== 1'b0 || cur_col_nc !== 5'd0) begin bad++; $display("FAIL nl_nc_cursor: got (%0d,%0d) want (0,0)", cur_row_nc, cur_col_nc); end
    endtask

    task automatic test_commands;
        logic [8:0] stim [0:7];
        int exp_row [0:7];
        int exp_col [0:7];
        int base, base_nc;
        bit ok;
        logic [8:0] got;
        stim    = '{9'h0C5, 9'h001, 9'h090, 9'h15A, 9'h00C, 9'h0CF, 9'h158, 9'h10A};
        exp_row = '{1, 0, 0, 1, 1, 1, 1, 0};
        exp_col = '{5, 0, 16, 1, 1, 15, 16, 0};
        exp_q    = '{9'h0C5, 9'h001, 9'h090, 9'h0C0, 9'h15A, 9'h00C, 9'h0CF, 9'h158, 9'h001};
        exp_nc_q = '{9'h0C5, 9'h001, 9'h090, 9'h0C0, 9'h15A, 9'h00C, 9'h0CF, 9'h158, 9'h080};
        base = obs_q.size();
        base_nc = obs_nc_q.size();
        for (int s = 0; s < 8; s++) begin
            push(stim[s]);
            wait_idle(ok);
            total++; if (!ok) begin bad++; $display("FAIL cmd_idle%0d: got timeout want idle", s); end
            total++;
            if (cur_row !== 1'(exp_row[s]) || cur_col !== 5'(exp_col[s])) begin
                bad++; $display("FAIL cmd_cursor%0d: got (%0d,%0d) want (%0d,%0d)", s, cur_row, cur_col, exp_row[s], exp_col[s]);
            end
            total++;
            if (cur_row_nc !== 1'(exp_row[s]) || cur_col_nc !== 5'(exp_col[s])) begin
                bad++; $display("FAIL cmd_nc_cursor%0d: got (%0d,%0d) want (%0d,%0d)", s, cur_row_nc, cur_col_nc, exp_row[s], exp_col[s]);
            end
        end
        total++;
        if (obs_q.size() - base != exp_q.size()) begin bad++; $display("FAIL cmd_count: got %0d want %0d", obs_q.size() - base, exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (base + i < obs_q.size()) ? obs_q[base + i] : 9'h1FF;
            total++;
            if (got !== exp_q[i]) begin bad++; $display("FAIL cmd_txn%0d: got %h want %h", i, got, exp_q[i]); end
            got = (base_nc + i < obs_nc_q.size()) ? obs_nc_q[base_nc + i] : 9'h1FF;
            total++;
            if (got !== exp_nc_q[i]) begin bad++; $display("FAIL cmd_nc_txn%0d: got %h want %h", i, got, exp_nc_q[i]); end
        end
    endtask

    task automatic test_back_to_back;
        int base;
        bit ok;
        int d;
        base = acc_q.size();
        push({1'b1, 8'h65});
        push({1'b1, 8'h66});
        push({1'b1, 8'h67});
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_idle: got timeout want idle"); end
        total++; if (acc_q.size() - base != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", acc_q.size() - base); end
        for (int i = 1; i < 3; i++) begin
            d = (base + i < acc_q.size()) ? acc_q[base + i] - acc_q[base + i - 1] : -1;
            total++; if (d != 4) begin bad++; $display("FAIL b2b_gap%0d: got %0d cycles want 4", i, d); end
        end
        total++; if (cur_row !== 1'b0 || cur_col !== 5'd3) begin bad++; $display("FAIL b2b_cursor: got (%0d,%0d) want (0,3)", cur_row, cur_col); end
    endtask

    task automatic test_backpressure;
        int base;
        bit ok;
        bit seen;
        logic [8:0] got;
        base = obs_q.size();
        host_ready = 1'b0;
        push({1'b1, 8'h61});
        push({1'b1, 8'h62});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = host_valid;
        end
        total++; if (!seen) begin bad++; $display("FAIL bp_valid_rise: got timeout want host_valid"); end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) init_done = 1'b0;
            if (i == 7) init_done = 1'b1;
            total++;
            if (host_valid !== 1'b1 || {host_rs, host_data} !== {1'b1, 8'h61} || fifo_rd_en !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d: got valid=%b txn=%h rd_en=%b want 1 161 0", i, host_valid, {host_rs, host_data}, fifo_rd_en);
            end
            @(negedge clk);
        end
        host_ready = 1'b1;
        @(negedge clk);
        total++; if (host_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop: got %b want 0", host_valid); end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_idle: got timeout want idle"); end
        got = (obs_q.size() == base + 2) ? obs_q[base] : 9'h1FF;
        total++; if (got !== {1'b1, 8'h61}) begin bad++; $display("FAIL bp_txn0: got %h want 161", got); end
        got = (obs_q.size() == base + 2) ? obs_q[base + 1] : 9'h1FF;
        total++; if (got !== {1'b1, 8'h62}) begin bad++; $display("FAIL bp_txn1: got %h want 162", got); end
        total++; if (cur_row !== 1'b0 || cur_col !== 5'd5) begin bad++; $display("FAIL bp_cursor: got (%0d,%0d) want (0,5)", cur_row, cur_col); end
    endtask

    task automatic test_init_gate;
        bit ok;
        @(negedge clk);
        init_done = 1'b0;
        push({1'b1, 8'h63});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (fifo_rd_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL gate_hold%0d: got rd_en=%b busy=%b want 0 0", i, fifo_rd_en, busy); end
        end
        init_done = 1'b1;
        @(negedge clk);
        total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL gate_rd_pulse: got %b want 1", fifo_rd_en); end
        @(negedge clk);
        total++; if (fifo_rd_en !== 1'b0 || host_valid !== 1'b0) begin bad++; $display("FAIL gate_rd_drop: got rd_en=%b valid=%b want 0 0", fifo_rd_en, host_valid); end
        @(negedge clk);
        total++;
        if (host_valid !== 1'b1 || {host_rs, host_data} !== {1'b1, 8'h63}) begin
            bad++; $display("FAIL gate_valid: got valid=%b txn=%h want 1 163", host_valid, {host_rs, host_data});
        end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL gate_idle: got timeout want idle"); end
        total++; if (cur_row !== 1'b0 || cur_col !== 5'd6) begin bad++; $display("FAIL gate_cursor: got (%0d,%0d) want (0,6)", cur_row, cur_col); end
    endtask

    task automatic test_reset_mid;
        int base;
        bit ok;
        bit seen;
        logic [8:0] got;
        host_ready = 1'b0;
        push({1'b1, 8'h0A});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = host_valid;
        end
        total++;
        if (!seen || fsm_state !== S_ADDR || host_data !== 8'hC0) begin
            bad++; $display("FAIL rmid_pre: got valid=%b state=%0d data=%h want 1 %0d c0", host_valid, fsm_state, host_data, S_ADDR);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({fifo_rd_en, host_valid, host_rs, host_data, busy} !== 12'h000) begin
            bad++; $display("FAIL rmid_outputs: got rd=%b v=%b rs=%b d=%h busy=%b want all 0", fifo_rd_en, host_valid, host_rs, host_data, busy);
        end
        total++; if (cur_row !== 1'b0 || cur_col !== 5'd0) begin bad++; $display("FAIL rmid_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col); end
        total++; if (fsm_state !== S_IDLE || host_valid_nc !== 1'b0) begin bad++; $display("FAIL rmid_state: got %0d nc_valid=%b want %0d 0", fsm_state, host_valid_nc, S_IDLE); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        host_ready = 1'b1;
        @(negedge clk);
        base = obs_q.size();
        push({1'b1, 8'h64});
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_idle: got timeout want idle"); end
        got = (obs_q.size() == base + 1) ? obs_q[base] : 9'h1FF;
        total++; if (got !== {1'b1, 8'h64}) begin bad++; $display("FAIL rmid_txn: got %h want 164 (single txn)", got); end
        total++; if (cur_row !== 1'b0 || cur_col !== 5'd1) begin bad++; $display("FAIL rmid_cursor_after: got (%0d,%0d) want (0,1)", cur_row, cur_col); end
    endtask

    initial begin
        test_reset();
        test_wrap_chars();
        test_newline();
        test_commands();
        test_back_to_back();
        test_backpressure();
        test_init_gate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_stream_formatter.md
# lcd_stream_formatter

Parametrised successor to the FIFO-to-LCD adapter: pops 9-bit `{rs, data}` entries from the sync FIFO and drives the HD44780 host handshake. It tracks the display cursor for a COLS x ROWS character panel, inserts set-DDRAM-address commands at line wrap, and interprets a newline character. On wrap past the last row it either clears the display or returns to the home address. It sits between `sync_fifo` and `hd44780_parallel_lcd` in the top level.

## Interface
- `COLS`, 16: visible columns per row, 8..40.
- `ROWS`, 2: rows, 1..4.
- `NL_EN`, 1: if 1, a data entry equal to `NL_CHAR` is treated as newline and not printed.
- `NL_CHAR`, 8'h0A: newline code.
- `WRAP_CLEAR`, 1: on wrap from the last row, 1 emits clear (8'h01); 0 emits set-address to row 0.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_dout` in 9: `[8]` = rs, `[7:0]` = data. Valid the cycle after `fifo_rd_en`.
- `fifo_rd_en` out 1: single-cycle pop strobe.
- `init_done` in 1: LCD controller initialised.
- `host_ready` in 1: LCD controller accepts a transaction.
- `host_valid` out 1: transaction offered.
- `host_rs` out 1: 1 = data, 0 = command.
- `host_data` out 8: data or command byte.
- `cur_row` out ROW_W: current row. ROW_W = max(1, clog2(ROWS)).
- `cur_col` out COL_W: current column, 0..COLS. COL_W = clog2(COLS+1).
- `busy` out 1: state is not S_IDLE.

## Operation
- States:
  - S_IDLE: if `init_done && !fifo_empty`, go to S_RD.
  - S_RD: `fifo_rd_en`=1 for this one cycle; go to S_CAP.
  - S_CAP: latch `fifo_dout` into `item`, classify, go to S_ADDR or S_ITEM.
  - S_ADDR: offer the inserted command; on accept go to S_ITEM, or S_IDLE for newline.
  - S_ITEM: offer `item`; on accept go to S_IDLE.
- Row base addresses: 8'h00, 8'h40, 8'h14, 8'h54. Set-address command = 8'h80 | (base + col).
- Printable char (rs=1, and not newline):
  - If `cur_col`==COLS (lazy wrap pending): S_ADDR emits the command for next row col 0, then S_ITEM emits the char.
  - After the char is accepted: `cur_col`=1 if a wrap occurred, else `cur_col`+1.
- Newline: S_ADDR emits the next-row command only, then `cur_row`=next, `cur_col`=0.
- Next row = (`cur_row`+1) mod ROWS. When it wraps to 0 and WRAP_CLEAR=1, the inserted command is 8'h01 instead of a set-address command.
- Commands (rs=0) pass through S_ITEM unchanged. On accept:
  - 8'h01, 8'h02, 8'h03: cursor to (0,0).
  - bit7 set: addr=data[6:0]. If addr is in [base_r, base_r+COLS) for some r < ROWS, cursor=(r, addr-base_r); otherwise `cur_col`=COLS, forcing re-address on the next char.
  - Any other command: cursor unchanged.
- Cursor registers update only on handshake accept, never at S_CAP.

## Timing
- Reset values: `fifo_rd_en`=0, `host_valid`=0, `host_rs`=0, `host_data`=0, `cur_row`=0, `cur_col`=0, `busy`=0, state S_IDLE.
- All outputs are registered.
- Accept = `host_valid && host_ready` in the same cycle. Once `host_valid` rises, `host_valid`, `host_rs` and `host_data` stay stable until accept, even if `init_done` falls.
- `host_valid` deasserts the cycle after accept. In back-to-back S_ADDR to S_ITEM it stays high, and `host_data` changes the cycle after accept.
- Latency from `fifo_empty` falling (in S_IDLE, `init_done`=1) to `host_valid`=1: 3 cycles (without insert).
- Minimum throughput: 4 cycles per entry, 5 with an inserted command.
- `init_done`=0 blocks only S_IDLE exit. No FIFO pop occurs before init.
- Reset mid-operation clears everything asynchronously. An in-flight entry is lost, by design.

## Structure
- Package `lcd_fmt_pkg`:
  - state enum;
  - CMD_CLEAR=8'h01, CMD_HOME=8'h02, CMD_SET_DDRAM=8'h80;
  - row-base function `row_base(row)`.
- Sub-module `lcd_cursor_tracker`: holds `cur_row`/`cur_col` and computes next row, wrap flag, set-address byte, and command decode. The FSM stays in `lcd_stream_formatter`.

## Test plan
All scenarios use COLS=16, ROWS=2, `host_ready` tied high unless stated.
- 17 chars 'A'..'Q' pushed after init -> 16 char txns; then rs=0 8'hC0; then 'Q'. Final `cur_row`=1, `cur_col`=1.
- At row 1, push 8'h0A with WRAP_CLEAR=1 -> single txn rs=0 8'h01, cursor (0,0). With WRAP_CLEAR=0 -> txn 8'h80.
- Push cmd 8'hC5 -> passed through, cursor (1,5). Push 8'h01 -> cursor (0,0). Push cmd 8'h90 -> `cur_col`=16; next char is preceded by 8'hC0.
- `host_ready` low for 10 cycles during S_ITEM -> `host_valid`/`host_rs`/`host_data` stable, `fifo_rd_en` stays 0. After ready rises, valid drops the next cycle.
- FIFO non-empty with `init_done`=0 for 20 cycles -> no `fifo_rd_en`. When `init_done` rises, `fifo_rd_en` pulses 1 cycle later and `host_valid` follows 2 cycles after that.
- Assert `rst_n`=0 mid S_ADDR -> all outputs reach reset values without a clock edge. After release, the next FIFO entry is processed normally.
